beta_writeback: RTL and testbench

Writeback stage of the Beta pipeline. It is the write-side driver of the register file.
- Accepts retiring instructions from the memory stage.
- Selects the write-back value: PC+4, ALU result or load data.
- Waits for outstanding load data, with a timeout.
- Drives the register-file write port, and publishes bypass and pending-load information to decode.

---
 rtl/beta_writeback.sv | 148 ++++++++++++++
 tb/tb_beta_writeback.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/beta_writeback.sv
// Beta pipeline writeback stage: selects the write-back value, waits for
// outstanding load data with a timeout, and drives the register-file write
// port plus the bypass and pending-load information seen by decode.
module beta_writeback #(
  parameter int MEM_TIMEOUT = 16,  // max WAIT_MEM cycles before giving up (>= 1)
  parameter int XP_ADDR     = 30,  // exception-pointer register
  parameter int R31_ADDR    = 31   // hardwired-zero register, never written
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  rc,
  input  logic [1:0]  wdsel,
  input  logic        werf,
  input  logic        exc,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] alu_result,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wdata,
  output logic        rf_we,
  output logic        byp_valid,
  output logic [4:0]  byp_addr,
  output logic [31:0] byp_data,
  output logic        load_pending,
  output logic [4:0]  pend_addr,
  output logic        mem_timeout
);

  localparam int              CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [4:0]       XP       = 5'(XP_ADDR);
  localparam logic [4:0]       R31      = 5'(R31_ADDR);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       pend_q, pend_d;
  logic [4:0]       rf_wa_q, rf_wa_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;
  logic             rf_we_q, rf_we_d;
  logic             timeout_q, timeout_d;

  logic        accept;
  logic        is_load;
  logic        do_write;
  logic [4:0]  dest;
  logic [31:0] sel_data;

  // Decode the retiring instruction: destination, write-back value, load-ness.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    accept   = in_valid && (state_q == S_IDLE);
    dest     = exc ? XP : rc;
    do_write = werf || exc;
    is_load  = !exc && (wdsel == 2'd2) && werf;
    sel_data = alu_result;               // wdsel 1 and reserved 3 both pick the ALU
    if (exc || wdsel == 2'd0) begin
      sel_data = pc_plus4;
    end
  end

  // Next-state logic: accept, load wait with timeout, write-port update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    rf_wa_d    = rf_wa_q;               // address/data hold when no write issues
    rf_wdata_d = rf_wdata_q;
    rf_we_d    = 1'b0;
    timeout_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_load) begin
            state_d = S_WAIT_MEM;
            cnt_d   = '0;
            pend_d  = dest;
          end else if (do_write && dest != R31) begin
            rf_we_d    = 1'b1;
            rf_wa_d    = dest;
            rf_wdata_d = sel_data;
          end
        end
      end
      S_WAIT_MEM: begin
        // Data arriving on the last allowed cycle still wins over the timeout.
        if (mem_rvalid) begin
          state_d = S_IDLE;
          if (pend_q != R31) begin
            rf_we_d    = 1'b1;
            rf_wa_d    = pend_q;
            rf_wdata_d = mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; async reset drops any outstanding load.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      rf_wa_q    <= '0;
      rf_wdata_q <= '0;
      rf_we_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      rf_wa_q    <= rf_wa_d;
      rf_wdata_q <= rf_wdata_d;
      rf_we_q    <= rf_we_d;
      timeout_q  <= timeout_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign load_pending = (state_q == S_WAIT_MEM);
  assign pend_addr    = pend_q;
  assign rf_we        = rf_we_q;
  assign rf_wa        = rf_wa_q;
  assign rf_wdata     = rf_wdata_q;
  assign byp_valid    = rf_we_q;
  assign byp_addr     = rf_wa_q;
  assign byp_data     = rf_wdata_q;
  assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_beta_writeback.sv
// Self-checking bench for beta_writeback: directed cases followed by random
// instruction streams, with expected writes/timeouts queued for a monitor.
module tb_beta_writeback;

  localparam int TO  = 4;
  localparam int XP  = 30;
  localparam int R31 = 31;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rc;
  logic [1:0]  wdsel;
  logic        werf;
  logic        exc;
  logic [31:0] pc_plus4;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wdata;
  logic        rf_we;
  logic        byp_valid;
  logic [4:0]  byp_addr;
  logic [31:0] byp_data;
  logic        load_pending;
  logic [4:0]  pend_addr;
  logic        mem_timeout;

  beta_writeback #(.MEM_TIMEOUT(TO), .XP_ADDR(XP), .R31_ADDR(R31)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .rc(rc), .wdsel(wdsel), .werf(werf), .exc(exc),
    .pc_plus4(pc_plus4), .alu_result(alu_result),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .rf_wa(rf_wa), .rf_wdata(rf_wdata), .rf_we(rf_we),
    .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data),
    .load_pending(load_pending), .pend_addr(pend_addr),
    .mem_timeout(mem_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_timeout;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [4:0]  hold_wa = '0;
  logic [31:0] hold_wd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: bypass mirrors the write port; every write/timeout matches the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("byp_valid_mirror", 32'(byp_valid), 32'(rf_we));
        check("byp_addr_mirror", 32'(byp_addr), 32'(rf_wa));
        check("byp_data_mirror", byp_data, rf_wdata);
        if (rf_we || mem_timeout) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", 32'({rf_we, mem_timeout}), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("event_is_timeout", 32'(mem_timeout), 32'(e.is_timeout));
            check("event_is_write", 32'(rf_we), 32'(!e.is_timeout));
            if (!e.is_timeout) begin
              check("wr_addr", 32'(rf_wa), 32'(e.addr));
              check("wr_data", rf_wdata, e.data);
              hold_wa = e.addr;
              hold_wd = e.data;
            end
          end
        end else begin
          check("hold_wa", 32'(rf_wa), 32'(hold_wa));
          check("hold_wd", rf_wdata, hold_wd);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic scramble();
    rc         = 5'($urandom);
    wdsel      = 2'($urandom);
    werf       = 1'($urandom);
    exc        = 1'($urandom);
    pc_plus4   = $urandom;
    alu_result = $urandom;
    mem_rdata  = $urandom;
  endtask

  // Issue one instruction; k = WAIT_MEM cycle index on which load data returns
  // (k >= TO means never, so the load must time out).
  task automatic issue(input logic [4:0] rc_i, input logic [1:0] wdsel_i,
                       input logic werf_i, input logic exc_i,
                       input logic [31:0] pc_i, input logic [31:0] alu_i,
                       input logic [31:0] md_i, input int k);
    logic [4:0]  dest;
    logic [31:0] val;
    bit          is_load;
    bit          writes;
    int          budget;
    dest    = exc_i ? 5'(XP) : rc_i;
    val     = (exc_i || wdsel_i == 2'd0) ? pc_i : alu_i;
    is_load = !exc_i && wdsel_i == 2'd2 && werf_i;
    budget  = 0;
    while (!in_ready && budget < 40) begin
      tick();
      budget++;
    end
    check("in_ready_before_issue", 32'(in_ready), 32'd1);
    in_valid = 1'b1; rc = rc_i; wdsel = wdsel_i; werf = werf_i; exc = exc_i;
    pc_plus4 = pc_i; alu_result = alu_i; mem_rdata = $urandom;
    tick();
    in_valid = 1'b0;
    scramble();
    if (!is_load) begin
      writes = (werf_i || exc_i) && dest != 5'(R31);
      if (writes) exp_q.push_back('{is_timeout: 1'b0, addr: dest, data: val});
      check("nonload_we", 32'(rf_we), 32'(writes));
      if (writes) begin
        check("nonload_wa", 32'(rf_wa), 32'(dest));
        check("nonload_wd", rf_wdata, val);
      end
      check("nonload_ready", 32'(in_ready), 32'd1);
    end else begin
      if (k >= TO) exp_q.push_back('{is_timeout: 1'b1, addr: dest, data: '0});
      else if (dest != 5'(R31)) exp_q.push_back('{is_timeout: 1'b0, addr: dest, data: md_i});
      for (int c = 0; c < TO; c++) begin
        check("wait_in_ready", 32'(in_ready), 32'd0);
        check("wait_pending", 32'(load_pending), 32'd1);
        check("wait_pend_addr", 32'(pend_addr), 32'(dest));
        check("wait_no_we", 32'(rf_we), 32'd0);
        if (c == k) begin
          mem_rvalid = 1'b1;
          mem_rdata  = md_i;
        end
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (c == k) break;
      end
      check("load_done_ready", 32'(in_ready), 32'd1);
      check("load_done_pending", 32'(load_pending), 32'd0);
      check("load_done_timeout", 32'(mem_timeout), 32'(k >= TO));
      check("load_done_we", 32'(rf_we), 32'(k < TO && dest != 5'(R31)));
      if (k < TO && dest != 5'(R31)) check("load_done_wd", rf_wdata, md_i);
    end
  endtask

  task automatic idle_cycles(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      mem_rvalid = stray;
      mem_rdata  = $urandom;
      tick();
      mem_rvalid = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; mem_rvalid = 1'b0;
    scramble();
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_rf_wa", 32'(rf_wa), 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_pending", 32'(load_pending), 32'd0);
    check("rst_pend_addr", 32'(pend_addr), 32'd0);
    check("rst_timeout", 32'(mem_timeout), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Directed cases
    issue(5'd5, 2'd1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_1234, 32'h0, 0);
    idle_cycles(1, 1'b0);
    issue(5'd7, 2'd2, 1'b1, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 2);
    issue(5'd12, 2'd2, 1'b1, 1'b0, 32'h0, 32'h0, 32'h1111_2222, TO);
    issue(5'd13, 2'd2, 1'b1, 1'b0, 32'h0, 32'h0, 32'h3333_4444, TO - 1);
    issue(5'd3, 2'd2, 1'b1, 1'b1, 32'h0000_0104, 32'h5555_5555, 32'h0, 0);
    issue(5'd31, 2'd1, 1'b1, 1'b0, 32'h0, 32'hAAAA_0001, 32'h0, 0);
    issue(5'd31, 2'd2, 1'b1, 1'b0, 32'h0, 32'h0, 32'hBBBB_0002, 1);
    issue(5'd10, 2'd1, 1'b0, 1'b0, 32'h0, 32'hCCCC_0003, 32'h0, 0);
    issue(5'd11, 2'd2, 1'b0, 1'b0, 32'h0, 32'hCCCC_0004, 32'h0, 0);
    issue(5'd9, 2'd3, 1'b1, 1'b0, 32'h0, 32'hDDDD_0005, 32'h0, 0);
    issue(5'd8, 2'd0, 1'b1, 1'b0, 32'h0000_2008, 32'hEEEE_0006, 32'h0, 0);
    idle_cycles(2, 1'b1);
    issue(5'd1, 2'd1, 1'b1, 1'b0, 32'h0, 32'h0101_0101, 32'h0, 0);
    issue(5'd2, 2'd1, 1'b1, 1'b0, 32'h0, 32'h0202_0202, 32'h0, 0);

    // Random stream
    for (int n = 0; n < 300; n++) begin
      logic [4:0] r;
      r = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
      issue(r, 2'($urandom), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 7) == 0), $urandom, $urandom, $urandom,
            $urandom_range(0, TO + 1));
      idle_cycles($urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a load wait, then a late return
    idle_cycles(2, 1'b0);
    check("queue_empty_before_reset", 32'(exp_q.size()), 32'd0);
    in_valid = 1'b1; rc = 5'd9; wdsel = 2'd2; werf = 1'b1; exc = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_reset_pending", 32'(load_pending), 32'd1);
    #2 reset = 1'b1;
    hold_wa = '0;
    hold_wd = '0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_pending", 32'(load_pending), 32'd0);
    check("midrst_rf_we", 32'(rf_we), 32'd0);
    check("midrst_rf_wa", 32'(rf_wa), 32'd0);
    check("midrst_rf_wdata", rf_wdata, 32'd0);
    check("midrst_pend_addr", 32'(pend_addr), 32'd0);
    tick();
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hFEED_F00D;
    tick();
    mem_rvalid = 1'b0;
    tick();
    check("late_rvalid_no_we", 32'(rf_we), 32'd0);
    check("late_rvalid_ready", 32'(in_ready), 32'd1);
    idle_cycles(3, 1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
